// File: rtl/gol_pkg.sv
// ============================================================================
// Module  : gol_pkg
// Brief   : Shared constants, types and index helper for the game_of_life engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gol_pkg;

    localparam int c_GRID_SIZE     = 8;
    localparam int c_UPDATE_PERIOD = 4;
    localparam int c_GEN_W         = 32;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } run_state_t;

    typedef struct packed {
        logic clk;
        logic pause;
        logic moveleft;
        logic moveright;
        logic moveup;
        logic movedown;
    } golcontrols;

    typedef struct packed {
        logic [c_GRID_SIZE*c_GRID_SIZE-1:0] grid;
        logic                               updatesignal;
        logic                               controlsignal;
        logic                               paused;
        logic [c_GEN_W-1:0]                 generation;
    } golmachine;

    function automatic int idx(input int x, input int y, input int n = c_GRID_SIZE);
        return x + y * n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/game_of_life_if.sv
// ============================================================================
// Module  : game_of_life_if
// Brief   : Control, load and display-side signals of the game_of_life engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface game_of_life_if #(
    parameter int GRID_SIZE = 8,
    parameter int GEN_W     = 32
);
    localparam int c_CW = $clog2(GRID_SIZE);

    logic                           pause;
    logic                           moveleft;
    logic                           moveright;
    logic                           moveup;
    logic                           movedown;
    logic                           toggle;
    logic                           load_en;
    logic [c_CW-1:0]                load_x;
    logic [c_CW-1:0]                load_y;
    logic                           load_val;
    logic [GRID_SIZE*GRID_SIZE-1:0] grid;
    logic [GEN_W-1:0]               generation;
    logic                           paused;
    logic [c_CW-1:0]                cursor_x;
    logic [c_CW-1:0]                cursor_y;
    logic                           updatesignal;
    logic                           controlsignal;

    modport master (
        output pause, moveleft, moveright, moveup, movedown, toggle,
        output load_en, load_x, load_y, load_val,
        input  grid, generation, paused, cursor_x, cursor_y,
        input  updatesignal, controlsignal
    );

    modport slave (
        input  pause, moveleft, moveright, moveup, movedown, toggle,
        input  load_en, load_x, load_y, load_val,
        output grid, generation, paused, cursor_x, cursor_y,
        output updatesignal, controlsignal
    );

endinterface

`default_nettype wire

// File: rtl/gol_cell_next.sv
// ============================================================================
// Module  : gol_cell_next
// Brief   : Next state of one cell from its 3x3 neighbourhood (centre = bit 4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gol_cell_next (
    input  logic [8:0] i_nbhd,
    output logic       o_next
);

    logic [3:0] w_cnt;

    always_comb begin
        w_cnt = {3'b000, i_nbhd[0]} + {3'b000, i_nbhd[1]} + {3'b000, i_nbhd[2]}
              + {3'b000, i_nbhd[3]} + {3'b000, i_nbhd[5]}
              + {3'b000, i_nbhd[6]} + {3'b000, i_nbhd[7]} + {3'b000, i_nbhd[8]};
        o_next = (w_cnt == 4'd3) | (i_nbhd[4] & (w_cnt == 4'd2));
    end

endmodule

`default_nettype wire

// File: rtl/game_of_life.sv
// ============================================================================
// Module  : game_of_life
// Brief   : Conway's Life engine with pause, cursor edit and cell load.
//           Define GOL_WRAP_EN for a toroidal grid.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module game_of_life
    import gol_pkg::*;
#(
    parameter int GRID_SIZE     = c_GRID_SIZE,
    parameter int UPDATE_PERIOD = c_UPDATE_PERIOD,
    parameter int GEN_W         = c_GEN_W
) (
    input  logic         clk,
    input  logic         reset,
    game_of_life_if.slave gif
);

    localparam int              c_CW    = $clog2(GRID_SIZE);
    localparam int              c_NCELL = GRID_SIZE * GRID_SIZE;
    localparam int              c_TW    = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam logic [c_CW-1:0] c_MAX   = c_CW'(GRID_SIZE - 1);
    localparam logic [c_TW-1:0] c_TMAX  = c_TW'(UPDATE_PERIOD - 1);

    // Bit order: {toggle, movedown, moveup, moveright, moveleft, pause}
    logic [5:0]        r_ctl_cur;
    logic [5:0]        r_ctl_prev;
    logic [5:0]        w_edge;
    logic              w_pause_edge;
    logic              w_mv_x;
    logic              w_mv_y;
    logic              w_toggle_ok;
    run_state_t        r_state;
    run_state_t        w_state_d;
    logic [c_TW-1:0]   r_timer;
    logic              w_step;
    logic [c_CW-1:0]   r_cx;
    logic [c_CW-1:0]   r_cy;
    logic [c_NCELL-1:0] r_grid;
    logic [c_NCELL-1:0] w_next_grid;
    logic [c_NCELL-1:0] w_grid_d;
    logic [GEN_W-1:0]  r_gen;
    logic              r_upd;
    logic              r_ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctl_cur  <= '0;
            r_ctl_prev <= '0;
        end else begin
            r_ctl_cur  <= {gif.toggle, gif.movedown, gif.moveup,
                           gif.moveright, gif.moveleft, gif.pause};
            r_ctl_prev <= r_ctl_cur;
        end
    end

    assign w_edge       = r_ctl_cur & ~r_ctl_prev;
    assign w_pause_edge = w_edge[0];
    assign w_mv_x       = w_edge[1] ^ w_edge[2];
    assign w_mv_y       = w_edge[3] ^ w_edge[4];
    assign w_toggle_ok  = w_edge[5] & (r_state == ST_PAUSED);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (w_pause_edge) begin
            w_state_d = (r_state == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
    end

    // A step that coincides with a pause edge still completes.
    assign w_step = (r_state == ST_RUN) && (r_timer == c_TMAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_pause_edge || (r_state == ST_PAUSED) || w_step) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cx <= '0;
            r_cy <= '0;
        end else begin
            if (w_mv_x) begin
                if (w_edge[1]) r_cx <= (r_cx == '0)    ? c_MAX : r_cx - c_CW'(1);
                else           r_cx <= (r_cx == c_MAX) ? '0    : r_cx + c_CW'(1);
            end
            if (w_mv_y) begin
                if (w_edge[3]) r_cy <= (r_cy == '0)    ? c_MAX : r_cy - c_CW'(1);
                else           r_cy <= (r_cy == c_MAX) ? '0    : r_cy + c_CW'(1);
            end
        end
    end

    for (genvar gy = 0; gy < GRID_SIZE; gy++) begin : g_row
        for (genvar gx = 0; gx < GRID_SIZE; gx++) begin : g_col
            localparam logic [c_CW-1:0] c_X = c_CW'(gx);
            localparam logic [c_CW-1:0] c_Y = c_CW'(gy);
            localparam int              c_I = gy * GRID_SIZE + gx;

            logic [8:0] w_nbhd;
            logic       w_cur_hit;
            logic       w_load_hit;
            logic       w_cell_d;

            for (genvar dy = 0; dy < 3; dy++) begin : g_dy
                for (genvar dx = 0; dx < 3; dx++) begin : g_dx
                    localparam int c_NX = gx + dx - 1;
                    localparam int c_NY = gy + dy - 1;
`ifdef GOL_WRAP_EN
                    localparam int c_WX = (c_NX + GRID_SIZE) % GRID_SIZE;
                    localparam int c_WY = (c_NY + GRID_SIZE) % GRID_SIZE;
                    assign w_nbhd[dy*3+dx] = r_grid[c_WY*GRID_SIZE+c_WX];
`else
                    if (c_NX >= 0 && c_NX < GRID_SIZE && c_NY >= 0 && c_NY < GRID_SIZE) begin : g_in
                        assign w_nbhd[dy*3+dx] = r_grid[c_NY*GRID_SIZE+c_NX];
                    end else begin : g_out
                        assign w_nbhd[dy*3+dx] = 1'b0;
                    end
`endif
                end
            end

            gol_cell_next u_cell (
                .i_nbhd (w_nbhd),
                .o_next (w_next_grid[c_I])
            );

            assign w_cur_hit  = (r_cx == c_X) && (r_cy == c_Y);
            assign w_load_hit = gif.load_en && (gif.load_x == c_X) && (gif.load_y == c_Y);

            // Priority low to high: step/hold, toggle, load.
            always_comb begin
                w_cell_d = w_step ? w_next_grid[c_I] : r_grid[c_I];
                if (w_toggle_ok && w_cur_hit) w_cell_d = ~w_cell_d;
                if (w_load_hit)               w_cell_d = gif.load_val;
            end

            assign w_grid_d[c_I] = w_cell_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grid <= '0;
            r_gen  <= '0;
            r_upd  <= 1'b0;
            r_ctrl <= 1'b0;
        end else begin
            r_grid <= w_grid_d;
            if (w_step) r_gen <= r_gen + GEN_W'(1);
            r_upd  <= w_step;
            r_ctrl <= w_pause_edge | w_mv_x | w_mv_y | w_toggle_ok;
        end
    end

    assign gif.grid          = r_grid;
    assign gif.generation    = r_gen;
    assign gif.paused        = (r_state == ST_PAUSED);
    assign gif.cursor_x      = r_cx;
    assign gif.cursor_y      = r_cy;
    assign gif.updatesignal  = r_upd;
    assign gif.controlsignal = r_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_game_of_life.sv
// ============================================================================
// Module  : tb_game_of_life
// Brief   : Self-checking bench for game_of_life against a rule-level Life model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_of_life;
    import gol_pkg::*;

    localparam int G  = 8;
    localparam int UP = 4;
    localparam int GW = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    game_of_life_if #(.GRID_SIZE(G), .GEN_W(GW)) gif ();

    game_of_life #(.GRID_SIZE(G), .UPDATE_PERIOD(UP), .GEN_W(GW)) dut (
        .clk   (clk),
        .reset (reset),
        .gif   (gif.slave)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    bit [G*G-1:0] mgrid;
    int           mgen;

    function automatic bit [G*G-1:0] life_step(input bit [G*G-1:0] g);
        bit [G*G-1:0] r;
        r = '0;
        for (int y = 0; y < G; y++) begin
            for (int x = 0; x < G; x++) begin
                int cnt;
                cnt = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int nx, ny;
                        nx = x + dx;
                        ny = y + dy;
`ifdef GOL_WRAP_EN
                        nx = (nx + G) % G;
                        ny = (ny + G) % G;
`endif
                        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < G && ny >= 0 && ny < G)
                            cnt += int'(g[idx(nx, ny, G)]);
                    end
                end
                r[idx(x, y, G)] = (cnt == 3) || (g[idx(x, y, G)] && cnt == 2);
            end
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        gif.pause = 0; gif.moveleft = 0; gif.moveright = 0; gif.moveup = 0;
        gif.movedown = 0; gif.toggle = 0; gif.load_en = 0;
        gif.load_x = '0; gif.load_y = '0; gif.load_val = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        mgrid = '0;
        mgen  = 0;
    endtask

    // Reset then pause before the first step can happen.
    task automatic reset_and_pause;
        do_reset();
        gif.pause = 1; tick();
        gif.pause = 0; tick();
    endtask

    task automatic press_pause;
        gif.pause = 1; tick();
        gif.pause = 0; tick();
    endtask

    task automatic load_cell(input int x, input int y, input bit v);
        gif.load_en = 1; gif.load_x = 3'(x); gif.load_y = 3'(y); gif.load_val = v;
        tick();
        gif.load_en = 0;
        mgrid[idx(x, y, G)] = v;
    endtask

    task automatic run_gens(input string name, input int n, input int first_lat);
        for (int k = 0; k < n; k++) begin
            int lat;
            int want;
            want = (k == 0) ? first_lat : UP;
            lat  = 0;
            do begin
                tick();
                lat++;
            end while (!gif.updatesignal && lat < 40);
            mgrid = life_step(mgrid);
            mgen++;
            n_checks++;
            if (!gif.updatesignal || lat != want) begin
                n_fail++;
                $display("FAIL %s latency gen%0d: got %0d cycles (update=%b) expected %0d", name, mgen, lat, gif.updatesignal, want);
            end
            n_checks++;
            if (gif.grid !== mgrid) begin
                n_fail++;
                $display("FAIL %s grid gen%0d: got %h expected %h", name, mgen, gif.grid, mgrid);
            end
            n_checks++;
            if (gif.generation !== GW'(mgen)) begin
                n_fail++;
                $display("FAIL %s generation: got %0d expected %0d", name, gif.generation, mgen);
            end
        end
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if (gif.grid !== '0 || gif.generation !== '0 || gif.paused !== 1'b0) begin
            n_fail++;
            $display("FAIL reset state: grid=%h gen=%0d paused=%b expected 0/0/0", gif.grid, gif.generation, gif.paused);
        end
        n_checks++;
        if (gif.cursor_x !== 3'd0 || gif.cursor_y !== 3'd0 || gif.updatesignal !== 1'b0 || gif.controlsignal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: cursor=(%0d,%0d) upd=%b ctl=%b expected (0,0) 0 0", gif.cursor_x, gif.cursor_y, gif.updatesignal, gif.controlsignal);
        end
        run_gens("reset_first_step", 1, UP);
    endtask

    task automatic test_blinker;
        reset_and_pause();
        load_cell(3, 2, 1); load_cell(3, 3, 1); load_cell(3, 4, 1);
        press_pause();
        run_gens("blinker", 2, UP);
        n_checks++;
        if (gif.grid !== ((64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35))) begin
            n_fail++;
            $display("FAIL blinker period: got %h expected vertical line at x=3", gif.grid);
        end
    endtask

    task automatic test_block;
        reset_and_pause();
        load_cell(2, 2, 1); load_cell(3, 2, 1); load_cell(2, 3, 1); load_cell(3, 3, 1);
        press_pause();
        run_gens("block", 5, UP);
    endtask

    task automatic test_corners;
        reset_and_pause();
        load_cell(0, 0, 1); load_cell(7, 0, 1); load_cell(0, 7, 1);
        press_pause();
        run_gens("corners", 1, UP);
    endtask

    task automatic test_random;
        for (int t = 0; t < 3; t++) begin
            reset_and_pause();
            for (int y = 0; y < G; y++)
                for (int x = 0; x < G; x++)
                    if ($urandom_range(7) < 3) load_cell(x, y, 1);
            press_pause();
            run_gens($sformatf("random%0d", t), 6, UP);
        end
    endtask

    task automatic test_pause_toggle;
        bit seen;
        reset_and_pause();
        load_cell(3, 2, 1); load_cell(3, 3, 1); load_cell(3, 4, 1);
        press_pause();
        run_gens("pause_run", 1, UP);
        press_pause();
        n_checks++;
        if (gif.paused !== 1'b1 || gif.controlsignal !== 1'b1) begin
            n_fail++;
            $display("FAIL pause edge: paused=%b ctl=%b expected 1 1", gif.paused, gif.controlsignal);
        end
        tick();
        n_checks++;
        if (gif.controlsignal !== 1'b0) begin
            n_fail++;
            $display("FAIL pause ctl pulse width: ctl=%b expected 0", gif.controlsignal);
        end
        seen = 0;
        repeat (20) begin
            tick();
            if (gif.updatesignal) seen = 1;
        end
        n_checks++;
        if (seen || gif.grid !== mgrid) begin
            n_fail++;
            $display("FAIL paused hold: update seen=%b grid=%h expected 0 %h", seen, gif.grid, mgrid);
        end
        gif.toggle = 1; tick();
        gif.toggle = 0; tick();
        mgrid[0] = ~mgrid[0];
        n_checks++;
        if (gif.grid !== mgrid || gif.controlsignal !== 1'b1) begin
            n_fail++;
            $display("FAIL paused toggle: grid=%h ctl=%b expected %h 1", gif.grid, gif.controlsignal, mgrid);
        end
        press_pause();
        run_gens("unpause", 1, UP);
        gif.toggle = 1; tick();
        gif.toggle = 0; tick();
        n_checks++;
        if (gif.controlsignal !== 1'b0) begin
            n_fail++;
            $display("FAIL running toggle ctl: got %b expected 0", gif.controlsignal);
        end
        run_gens("running_toggle", 1, UP - 2);
    endtask

    task automatic test_cursor;
        int pulses;
        do_reset();
        gif.moveleft = 1; tick();
        gif.moveleft = 0; tick();
        n_checks++;
        if (gif.cursor_x !== 3'd7 || gif.cursor_y !== 3'd0 || gif.controlsignal !== 1'b1) begin
            n_fail++;
            $display("FAIL moveleft wrap: cursor=(%0d,%0d) ctl=%b expected (7,0) 1", gif.cursor_x, gif.cursor_y, gif.controlsignal);
        end
        gif.moveleft = 1; gif.moveright = 1; tick();
        gif.moveleft = 0; gif.moveright = 0; tick();
        n_checks++;
        if (gif.cursor_x !== 3'd7 || gif.controlsignal !== 1'b0) begin
            n_fail++;
            $display("FAIL left+right cancel: cursor_x=%0d ctl=%b expected 7 0", gif.cursor_x, gif.controlsignal);
        end
        gif.moveright = 1; tick();
        gif.moveright = 0; tick();
        n_checks++;
        if (gif.cursor_x !== 3'd0) begin
            n_fail++;
            $display("FAIL moveright wrap: cursor_x=%0d expected 0", gif.cursor_x);
        end
        pulses = 0;
        gif.moveup = 1;
        repeat (10) begin
            tick();
            if (gif.controlsignal) pulses++;
        end
        gif.moveup = 0; tick(); tick();
        n_checks++;
        if (gif.cursor_y !== 3'd7 || pulses != 1) begin
            n_fail++;
            $display("FAIL held moveup: cursor_y=%0d pulses=%0d expected 7 1", gif.cursor_y, pulses);
        end
        gif.movedown = 1; gif.moveright = 1; tick();
        gif.movedown = 0; gif.moveright = 0; tick();
        n_checks++;
        if (gif.cursor_x !== 3'd1 || gif.cursor_y !== 3'd0 || gif.controlsignal !== 1'b1) begin
            n_fail++;
            $display("FAIL diagonal move: cursor=(%0d,%0d) ctl=%b expected (1,0) 1", gif.cursor_x, gif.cursor_y, gif.controlsignal);
        end
    endtask

    task automatic test_load_in_step;
        reset_and_pause();
        load_cell(3, 2, 1); load_cell(3, 3, 1); load_cell(3, 4, 1);
        press_pause();
        tick(); tick(); tick();
        gif.load_en = 1; gif.load_x = 3'd3; gif.load_y = 3'd3; gif.load_val = 0;
        tick();
        gif.load_en = 0;
        mgrid = life_step(mgrid);
        mgrid[idx(3, 3, G)] = 0;
        n_checks++;
        if (gif.updatesignal !== 1'b1 || gif.grid !== mgrid || gif.generation !== GW'(1)) begin
            n_fail++;
            $display("FAIL load in step: upd=%b grid=%h gen=%0d expected 1 %h 1", gif.updatesignal, gif.grid, gif.generation, mgrid);
        end
    endtask

    task automatic test_toggle_load;
        reset_and_pause();
        gif.toggle = 1; tick();
        gif.toggle = 0;
        gif.load_en = 1; gif.load_x = 3'd0; gif.load_y = 3'd0; gif.load_val = 0;
        tick();
        gif.load_en = 0;
        n_checks++;
        if (gif.grid !== '0) begin
            n_fail++;
            $display("FAIL toggle+load: grid=%h expected 0", gif.grid);
        end
    endtask

    task automatic test_reset_mid;
        reset_and_pause();
        gif.moveright = 1; gif.movedown = 1; tick();
        gif.moveright = 0; gif.movedown = 0; tick();
        load_cell(3, 2, 1); load_cell(3, 3, 1); load_cell(3, 4, 1);
        press_pause();
        run_gens("pre_reset", 3, UP);
        tick();
        reset = 1;
        tick();
        n_checks++;
        if (gif.grid !== '0 || gif.generation !== '0 || gif.paused !== 1'b0 ||
            gif.cursor_x !== 3'd0 || gif.cursor_y !== 3'd0 ||
            gif.updatesignal !== 1'b0 || gif.controlsignal !== 1'b0) begin
            n_fail++;
            $display("FAIL mid reset: grid=%h gen=%0d paused=%b cursor=(%0d,%0d) upd=%b ctl=%b expected all 0",
                     gif.grid, gif.generation, gif.paused, gif.cursor_x, gif.cursor_y, gif.updatesignal, gif.controlsignal);
        end
        reset = 0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_blinker();
        test_block();
        test_corners();
        test_random();
        test_pause_toggle();
        test_cursor();
        test_load_in_step();
        test_toggle_load();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
